// File: rtl/serial_operand_sequencer_if.sv
// Signal bundle between the byte-serial operand sequencer and its environment
// (switches/button, arithmetic unit, 7-seg display decoder).
interface serial_operand_sequencer_if #(
    parameter int BYTE_W    = 8,
    parameter int NBYTES    = 4,
    parameter int NOPS      = 2,
    parameter int RES_BYTES = 4
);
    localparam int MAXB  = (NBYTES > RES_BYTES) ? NBYTES : RES_BYTES;
    localparam int IDX_W = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int OPS_W = (NOPS > 1) ? $clog2(NOPS) : 1;

    logic                          enter;
    logic [BYTE_W-1:0]             inputdata;
    logic [NOPS*NBYTES*BYTE_W-1:0] operands;
    logic                          op_valid;
    logic                          op_ready;
    logic [RES_BYTES*BYTE_W-1:0]   result;
    logic                          res_valid;
    logic [BYTE_W-1:0]             disp_byte;
    logic [OPS_W-1:0]              op_sel;
    logic [IDX_W-1:0]              byte_idx;
    logic [1:0]                    phase;

    modport master (
        input  enter, inputdata, op_ready, result, res_valid,
        output operands, op_valid, disp_byte, op_sel, byte_idx, phase
    );

    modport slave (
        output enter, inputdata, op_ready, result, res_valid,
        input  operands, op_valid, disp_byte, op_sel, byte_idx, phase
    );
endinterface

// File: rtl/serial_operand_sequencer.sv
// Byte-serial operand entry, valid/ready hand-off to an arithmetic unit and
// byte-by-byte result readout. Bytes are entered and shown MSB first.
module serial_operand_sequencer #(
    parameter int BYTE_W    = 8,
    parameter int NBYTES    = 4,
    parameter int NOPS      = 2,
    parameter int RES_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    serial_operand_sequencer_if.master   bus
);
    localparam int MAXB  = (NBYTES > RES_BYTES) ? NBYTES : RES_BYTES;
    localparam int IDX_W = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int OPS_W = (NOPS > 1) ? $clog2(NOPS) : 1;
    localparam int OP_W  = NBYTES * BYTE_W;
    localparam int NB    = NOPS * NBYTES;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t                      state_reg, state_next;
    logic [OPS_W-1:0]            op_sel_reg, op_sel_next;
    logic [IDX_W-1:0]            byte_idx_reg, byte_idx_next;
    logic [BYTE_W-1:0]           disp_reg, disp_next;
    logic                        enter_q_reg;
    logic [RES_BYTES*BYTE_W-1:0] result_reg;
    logic [BYTE_W-1:0]           op_bytes_reg [NB];

    logic                        press;
    logic                        load_we;
    logic                        clear_ops;
    logic                        capture;
    logic [NB-1:0]               byte_we;
    logic [BYTE_W-1:0]           res_bytes [RES_BYTES];
    logic [IDX_W-1:0]            idx_inc;
    logic [BYTE_W-1:0]           shown_byte;
    logic [NOPS*OP_W-1:0]        operands_flat;

    assign press   = bus.enter & ~enter_q_reg;
    assign idx_inc = byte_idx_reg + IDX_W'(1);

    // Flat byte f = k*NBYTES + i is byte i (0 = MSB) of operand k.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_op_byte
            localparam int K = gi / NBYTES;
            localparam int I = gi % NBYTES;
            assign byte_we[gi] = load_we && (op_sel_reg == OPS_W'(K))
                                         && (byte_idx_reg == IDX_W'(I));
            assign operands_flat[K*OP_W + (NBYTES-1-I)*BYTE_W +: BYTE_W] = op_bytes_reg[gi];
        end
        for (gi = 0; gi < RES_BYTES; gi++) begin : g_res_byte
            assign res_bytes[gi] = result_reg[(RES_BYTES-1-gi)*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        shown_byte = '0;
        for (int i = 0; i < RES_BYTES; i++) begin
            if (idx_inc == IDX_W'(i)) shown_byte = res_bytes[i];
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_sel_next   = op_sel_reg;
        byte_idx_next = byte_idx_reg;
        disp_next     = disp_reg;
        load_we       = 1'b0;
        clear_ops     = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            LOAD: begin
                if (press) begin
                    load_we   = 1'b1;
                    disp_next = bus.inputdata;
                    if (byte_idx_reg == IDX_W'(NBYTES-1)) begin
                        byte_idx_next = '0;
                        if (op_sel_reg == OPS_W'(NOPS-1)) begin
                            op_sel_next = '0;
                            state_next  = ISSUE;
                        end else begin
                            op_sel_next = op_sel_reg + OPS_W'(1);
                        end
                    end else begin
                        byte_idx_next = idx_inc;
                    end
                end
            end
            ISSUE: begin
                if (bus.op_ready) state_next = WAIT;
            end
            WAIT: begin
                // Only reachable a cycle after the handshake, so a res_valid
                // coincident with it is never seen here.
                if (bus.res_valid) begin
                    capture       = 1'b1;
                    disp_next     = bus.result[RES_BYTES*BYTE_W-1 -: BYTE_W];
                    byte_idx_next = '0;
                    state_next    = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    if (byte_idx_reg == IDX_W'(RES_BYTES-1)) begin
                        state_next    = LOAD;
                        byte_idx_next = '0;
                        op_sel_next   = '0;
                        disp_next     = '0;
                        clear_ops     = 1'b1;
                    end else begin
                        byte_idx_next = idx_inc;
                        disp_next     = shown_byte;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= LOAD;
            op_sel_reg   <= '0;
            byte_idx_reg <= '0;
            disp_reg     <= '0;
            enter_q_reg  <= 1'b0;
            result_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            op_sel_reg   <= op_sel_next;
            byte_idx_reg <= byte_idx_next;
            disp_reg     <= disp_next;
            enter_q_reg  <= bus.enter;
            if (capture) result_reg <= bus.result;
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < NB; f++) begin
            if (reset || clear_ops) op_bytes_reg[f] <= '0;
            else if (byte_we[f])    op_bytes_reg[f] <= bus.inputdata;
        end
    end

    assign bus.operands  = operands_flat;
    assign bus.op_valid  = (state_reg == ISSUE);
    assign bus.disp_byte = disp_reg;
    assign bus.op_sel    = op_sel_reg;
    assign bus.byte_idx  = byte_idx_reg;
    assign bus.phase     = state_reg;
endmodule

// File: tb/tb_serial_operand_sequencer.sv
// Directed bench: default-parameter instance plus a NOPS=3/NBYTES=2/RES_BYTES=1 instance.
module tb_serial_operand_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_operand_sequencer_if #(.BYTE_W(8), .NBYTES(4), .NOPS(2), .RES_BYTES(4)) bus_a ();
    serial_operand_sequencer_if #(.BYTE_W(8), .NBYTES(2), .NOPS(3), .RES_BYTES(1)) bus_b ();

    serial_operand_sequencer #(.BYTE_W(8), .NBYTES(4), .NOPS(2), .RES_BYTES(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    serial_operand_sequencer #(.BYTE_W(8), .NBYTES(2), .NOPS(3), .RES_BYTES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One press: enter high 2 clk, low 2 clk; returns 1 time unit after an edge.
    task automatic press_a(input logic [7:0] d);
        bus_a.inputdata = d;
        bus_a.enter = 1'b1;
        step(2);
        bus_a.enter = 1'b0;
        step(2);
        $display("[TB] press A data=%h phase=%0d sel=%0d idx=%0d disp=%h",
                 d, bus_a.phase, bus_a.op_sel, bus_a.byte_idx, bus_a.disp_byte);
    endtask

    task automatic press_b(input logic [7:0] d);
        bus_b.inputdata = d;
        bus_b.enter = 1'b1;
        step(2);
        bus_b.enter = 1'b0;
        step(2);
        $display("[TB] press B data=%h phase=%0d sel=%0d idx=%0d disp=%h",
                 d, bus_b.phase, bus_b.op_sel, bus_b.byte_idx, bus_b.disp_byte);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_phase"}, 64'(bus_a.phase), 64'd0);
        check({tag, "_opvalid"}, 64'(bus_a.op_valid), 64'd0);
        check({tag, "_opsel"}, 64'(bus_a.op_sel), 64'd0);
        check({tag, "_idx"}, 64'(bus_a.byte_idx), 64'd0);
        check({tag, "_disp"}, 64'(bus_a.disp_byte), 64'd0);
        check({tag, "_operands"}, bus_a.operands, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus_a.enter = 1'b0; bus_a.inputdata = '0; bus_a.op_ready = 1'b0;
        bus_a.result = '0;  bus_a.res_valid = 1'b0;
        bus_b.enter = 1'b0; bus_b.inputdata = '0; bus_b.op_ready = 1'b0;
        bus_b.result = '0;  bus_b.res_valid = 1'b0;
        step(3);
        check_idle_a("reset");
        check("reset_b_operands", 64'(bus_b.operands), 64'd0);
        reset = 1'b0;
        step(1);

        // 1: load A = 3F800000, B = 40000000
        press_a(8'h3F); press_a(8'h80); press_a(8'h00);
        check("t1_mid_idx", 64'(bus_a.byte_idx), 64'd3);
        press_a(8'h00);
        check("t1_opsel_wrap", 64'(bus_a.op_sel), 64'd1);
        check("t1_idx_wrap", 64'(bus_a.byte_idx), 64'd0);
        press_a(8'h40); press_a(8'h00); press_a(8'h00); press_a(8'h00);
        check("t1_phase", 64'(bus_a.phase), 64'd1);
        check("t1_opvalid", 64'(bus_a.op_valid), 64'd1);
        check("t1_operands", bus_a.operands, 64'h40000000_3F800000);
        check("t1_disp", 64'(bus_a.disp_byte), 64'h00);
        check("t1_opsel", 64'(bus_a.op_sel), 64'd0);

        // 2: op_ready low 10 cycles, then a single-cycle high
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t2_hold_opvalid", 64'(bus_a.op_valid), 64'd1);
            check("t2_hold_operands", bus_a.operands, 64'h40000000_3F800000);
        end
        bus_a.op_ready = 1'b1;
        bus_a.res_valid = 1'b1;
        step(1);
        bus_a.op_ready = 1'b0;
        bus_a.res_valid = 1'b0;
        check("t2_opvalid_drop", 64'(bus_a.op_valid), 64'd0);
        check("t2_phase_wait", 64'(bus_a.phase), 64'd2);
        step(1);
        check("t2_coincident_resvalid", 64'(bus_a.phase), 64'd2);

        // 3: presses in WAIT ignored, then result readout
        press_a(8'h11); press_a(8'h22); press_a(8'h33);
        check("t3_wait_phase", 64'(bus_a.phase), 64'd2);
        check("t3_wait_disp", 64'(bus_a.disp_byte), 64'h00);
        bus_a.result = 32'h40400000;
        bus_a.res_valid = 1'b1;
        step(1);
        bus_a.res_valid = 1'b0;
        bus_a.result = 32'hDEADBEEF;
        check("t3_show_phase", 64'(bus_a.phase), 64'd3);
        check("t3_show_disp0", 64'(bus_a.disp_byte), 64'h40);
        check("t3_show_idx0", 64'(bus_a.byte_idx), 64'd0);
        press_a(8'hFF);
        check("t3_show_disp1", 64'(bus_a.disp_byte), 64'h40);
        check("t3_show_idx1", 64'(bus_a.byte_idx), 64'd1);
        press_a(8'hFF);
        check("t3_show_disp2", 64'(bus_a.disp_byte), 64'h00);
        press_a(8'hFF);
        check("t3_show_disp3", 64'(bus_a.disp_byte), 64'h00);
        check("t3_show_idx3", 64'(bus_a.byte_idx), 64'd3);
        press_a(8'hFF);
        check_idle_a("t3_back");

        // 4: held enter gives exactly one press
        bus_a.inputdata = 8'hAB;
        bus_a.enter = 1'b1;
        step(20);
        bus_a.enter = 1'b0;
        step(2);
        check("t4_idx", 64'(bus_a.byte_idx), 64'd1);
        check("t4_opsel", 64'(bus_a.op_sel), 64'd0);
        check("t4_operands", bus_a.operands, 64'h00000000_AB000000);
        check("t4_disp", 64'(bus_a.disp_byte), 64'hAB);

        // 5: reset after five bytes, then a full reload
        press_a(8'h01); press_a(8'h02); press_a(8'h03); press_a(8'h04);
        check("t5_pre_operands", bus_a.operands, 64'h04000000_AB010203);
        check("t5_pre_idx", 64'(bus_a.byte_idx), 64'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_idle_a("t5_reset");
        press_a(8'h12); press_a(8'h34); press_a(8'h56); press_a(8'h78);
        press_a(8'h9A); press_a(8'hBC); press_a(8'hDE); press_a(8'hF0);
        check("t5_reload_operands", bus_a.operands, 64'h9ABCDEF0_12345678);
        check("t5_reload_opvalid", 64'(bus_a.op_valid), 64'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_idle_a("t5_issue_abort");

        // 6: NOPS=3, NBYTES=2, RES_BYTES=1; first byte of each operand is its MSB
        press_b(8'h11); press_b(8'h22);
        check("t6_opsel1", 64'(bus_b.op_sel), 64'd1);
        press_b(8'h33); press_b(8'h44); press_b(8'h55); press_b(8'h66);
        check("t6_operands", 64'(bus_b.operands), 64'h0000_5566_3344_1122);
        check("t6_opvalid", 64'(bus_b.op_valid), 64'd1);
        check("t6_phase_issue", 64'(bus_b.phase), 64'd1);
        bus_b.op_ready = 1'b1;
        step(1);
        bus_b.op_ready = 1'b0;
        check("t6_phase_wait", 64'(bus_b.phase), 64'd2);
        bus_b.result = 8'hA5;
        bus_b.res_valid = 1'b1;
        step(1);
        check("t6_show_phase", 64'(bus_b.phase), 64'd3);
        check("t6_show_disp", 64'(bus_b.disp_byte), 64'hA5);
        press_b(8'h77);
        bus_b.res_valid = 1'b0;
        check("t6_back_phase", 64'(bus_b.phase), 64'd0);
        check("t6_back_disp", 64'(bus_b.disp_byte), 64'h00);
        check("t6_back_operands", 64'(bus_b.operands), 64'd0);

        // op_ready already high when operands complete: handshake on first ISSUE cycle
        bus_b.op_ready = 1'b1;
        press_b(8'h01); press_b(8'h02); press_b(8'h03);
        press_b(8'h04); press_b(8'h05); press_b(8'h06);
        bus_b.op_ready = 1'b0;
        check("t6_early_ready_phase", 64'(bus_b.phase), 64'd2);
        check("t6_early_ready_opvalid", 64'(bus_b.op_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
